reservation_station: RTL and testbench

- Unified reservation station sitting directly upstream of the integer ALU.
- Holds dispatched ALU/branch/jump micro-ops until both source operands are available.
- Snoops the ALU and LSB result broadcasts to capture operands, then issues one ready entry per cycle to the ALU through registered outputs.
- Reports fullness to the dispatcher; a ROB misprediction flush empties all entries.

---
 rtl/reservation_station_pkg.sv | 13 +
 rtl/rs_select.sv | 25 ++
 rtl/reservation_station.sv | 153 +++++++++++++++
 tb/tb_reservation_station.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// Shared constants for the ALU reservation station and its helpers.
// Defaults here size the top level; tag 0 and opcode 0 carry special meaning.
package reservation_station_pkg;
    localparam int DATA_WIDTH          = 32;
    localparam int ROB_TAG_WIDTH       = 4;
    localparam int INSIDE_OPCODE_WIDTH = 6;
    localparam int RS_SIZE             = 16;
    localparam int RS_INDEX_WIDTH      = $clog2(RS_SIZE);

    localparam logic [ROB_TAG_WIDTH-1:0]       ZERO_TAG_ROB = '0;
    localparam logic [DATA_WIDTH-1:0]          ZERO_DATA    = '0;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] NOP          = '0;
endpackage

// File: rtl/rs_select.sv
// Lowest-index priority encoder: request vector -> index of first set bit + found flag.
// Latency: purely combinational.
// Backpressure: none; found=0 when the request vector is empty.
module rs_select
    import reservation_station_pkg::*;
#(
    parameter int N = RS_SIZE,
    parameter int W = RS_INDEX_WIDTH
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         found
);
    // Scanning downward lets the lowest set bit be the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/reservation_station.sv
// Unified ALU reservation station: holds micro-ops until operands arrive, issues one per cycle.
// Latency: ready-at-dispatch entry issues on the edge after it is written; woken entries one edge after wakeup.
// Backpressure: out_full while every entry is busy; rdy low freezes state and outputs a NOP.
module reservation_station #(
    parameter int RS_SIZE = reservation_station_pkg::RS_SIZE,
    parameter int DATA_W  = reservation_station_pkg::DATA_WIDTH,
    parameter int TAG_W   = reservation_station_pkg::ROB_TAG_WIDTH,
    parameter int OP_W    = reservation_station_pkg::INSIDE_OPCODE_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              in_enable,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_value1,
    input  logic [TAG_W-1:0]  in_tag1,
    input  logic [DATA_W-1:0] in_value2,
    input  logic [TAG_W-1:0]  in_tag2,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [TAG_W-1:0]  in_rob_tag,
    input  logic [TAG_W-1:0]  in_alu_tag,
    input  logic [DATA_W-1:0] in_alu_value,
    input  logic [TAG_W-1:0]  in_lsb_tag,
    input  logic [DATA_W-1:0] in_lsb_value,
    input  logic              in_flush,
    output logic              out_full,
    output logic [OP_W-1:0]   out_op,
    output logic [DATA_W-1:0] out_value1,
    output logic [DATA_W-1:0] out_value2,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_pc,
    output logic [TAG_W-1:0]  out_rob_tag
);
    import reservation_station_pkg::*;

    localparam int IDX_W = $clog2(RS_SIZE);
    localparam logic [OP_W-1:0]   OP_NOP   = OP_W'(NOP);
    localparam logic [TAG_W-1:0]  NO_TAG   = TAG_W'(ZERO_TAG_ROB);
    localparam logic [DATA_W-1:0] ZERO_VAL = DATA_W'(ZERO_DATA);

    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] v1;
        logic [TAG_W-1:0]  t1;
        logic [DATA_W-1:0] v2;
        logic [TAG_W-1:0]  t2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [TAG_W-1:0]  rob_tag;
    } rs_entry_t;

    rs_entry_t         ent [RS_SIZE];
    logic [RS_SIZE-1:0] free_vec, ready_vec;
    logic [IDX_W-1:0]   free_idx, iss_idx;
    logic               free_found, iss_found, dispatch_en;
    logic [DATA_W-1:0]  new_v1, new_v2;
    logic [TAG_W-1:0]   new_t1, new_t2;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            free_vec[i]  = !ent[i].busy;
            ready_vec[i] = ent[i].busy && ent[i].t1 == NO_TAG && ent[i].t2 == NO_TAG;
        end
    end

    assign out_full    = &(~free_vec);
    assign dispatch_en = rdy && in_enable && free_found && !in_flush;

    rs_select #(.N(RS_SIZE), .W(IDX_W)) u_free_sel (.req(free_vec),  .idx(free_idx), .found(free_found));
    rs_select #(.N(RS_SIZE), .W(IDX_W)) u_iss_sel  (.req(ready_vec), .idx(iss_idx),  .found(iss_found));

    // Same-cycle forwarding from the broadcast buses; ALU wins a double match.
    always_comb begin
        new_v1 = in_value1;
        new_t1 = in_tag1;
        new_v2 = in_value2;
        new_t2 = in_tag2;
        if (in_tag1 != NO_TAG && in_tag1 == in_alu_tag) begin
            new_v1 = in_alu_value;
            new_t1 = NO_TAG;
        end else if (in_tag1 != NO_TAG && in_tag1 == in_lsb_tag) begin
            new_v1 = in_lsb_value;
            new_t1 = NO_TAG;
        end
        if (in_tag2 != NO_TAG && in_tag2 == in_alu_tag) begin
            new_v2 = in_alu_value;
            new_t2 = NO_TAG;
        end else if (in_tag2 != NO_TAG && in_tag2 == in_lsb_tag) begin
            new_v2 = in_lsb_value;
            new_t2 = NO_TAG;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
            out_op      <= OP_NOP;
            out_value1  <= ZERO_VAL;
            out_value2  <= ZERO_VAL;
            out_imm     <= ZERO_VAL;
            out_pc      <= ZERO_VAL;
            out_rob_tag <= NO_TAG;
        end else if (in_flush) begin
            for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
            out_op      <= OP_NOP;
            out_rob_tag <= NO_TAG;
        end else if (!rdy) begin
            out_op      <= OP_NOP;
            out_rob_tag <= NO_TAG;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (ent[i].busy && ent[i].t1 != NO_TAG) begin
                    if (ent[i].t1 == in_alu_tag) begin
                        ent[i].v1 <= in_alu_value;
                        ent[i].t1 <= NO_TAG;
                    end else if (ent[i].t1 == in_lsb_tag) begin
                        ent[i].v1 <= in_lsb_value;
                        ent[i].t1 <= NO_TAG;
                    end
                end
                if (ent[i].busy && ent[i].t2 != NO_TAG) begin
                    if (ent[i].t2 == in_alu_tag) begin
                        ent[i].v2 <= in_alu_value;
                        ent[i].t2 <= NO_TAG;
                    end else if (ent[i].t2 == in_lsb_tag) begin
                        ent[i].v2 <= in_lsb_value;
                        ent[i].t2 <= NO_TAG;
                    end
                end
            end
            // Issue only looks at entries already ready before this edge.
            if (iss_found) begin
                out_op               <= ent[iss_idx].op;
                out_value1           <= ent[iss_idx].v1;
                out_value2           <= ent[iss_idx].v2;
                out_imm              <= ent[iss_idx].imm;
                out_pc               <= ent[iss_idx].pc;
                out_rob_tag          <= ent[iss_idx].rob_tag;
                ent[iss_idx].busy    <= 1'b0;
            end else begin
                out_op      <= OP_NOP;
                out_rob_tag <= NO_TAG;
            end
            if (dispatch_en) begin
                ent[free_idx] <= '{busy: 1'b1, op: in_op, v1: new_v1, t1: new_t1,
                                   v2: new_v2, t2: new_t2, imm: in_imm, pc: in_pc,
                                   rob_tag: in_rob_tag};
            end
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: vector table for single-entry flows, scoreboard for the full-drain case.
module tb_reservation_station;
    logic        clk = 1'b0;
    logic        rst, rdy, in_enable, in_flush;
    logic [5:0]  in_op;
    logic [31:0] in_value1, in_value2, in_imm, in_pc, in_alu_value, in_lsb_value;
    logic [3:0]  in_tag1, in_tag2, in_rob_tag, in_alu_tag, in_lsb_tag;
    logic        out_full;
    logic [5:0]  out_op;
    logic [31:0] out_value1, out_value2, out_imm, out_pc;
    logic [3:0]  out_rob_tag;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reservation_station dut (
        .clk(clk), .rst(rst), .rdy(rdy), .in_enable(in_enable), .in_op(in_op),
        .in_value1(in_value1), .in_tag1(in_tag1), .in_value2(in_value2), .in_tag2(in_tag2),
        .in_imm(in_imm), .in_pc(in_pc), .in_rob_tag(in_rob_tag),
        .in_alu_tag(in_alu_tag), .in_alu_value(in_alu_value),
        .in_lsb_tag(in_lsb_tag), .in_lsb_value(in_lsb_value), .in_flush(in_flush),
        .out_full(out_full), .out_op(out_op), .out_value1(out_value1), .out_value2(out_value2),
        .out_imm(out_imm), .out_pc(out_pc), .out_rob_tag(out_rob_tag)
    );

    typedef struct {
        logic        en;
        logic [5:0]  op;
        logic [31:0] v1;
        logic [3:0]  t1;
        logic [31:0] v2;
        logic [3:0]  t2;
        logic [3:0]  rob;
        logic [3:0]  at;
        logic [31:0] av;
        logic [3:0]  lt;
        logic [31:0] lv;
        logic [5:0]  e_op;
        logic [31:0] e_v1;
        logic [31:0] e_v2;
        logic [3:0]  e_rob;
    } vec_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] v1, v2, imm, pc;
        logic [3:0]  rob;
    } exp_t;

    vec_t vecs [20];
    exp_t sbq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] imm_of(input logic [3:0] rob);
        return (32'(rob) << 8) | 32'h11;
    endfunction

    function automatic logic [31:0] pc_of(input logic [3:0] rob);
        return 32'h1000 + 32'(rob) * 4;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rdy = 1'b1; in_enable = 1'b0; in_flush = 1'b0; in_op = '0;
        in_value1 = '0; in_tag1 = '0; in_value2 = '0; in_tag2 = '0;
        in_imm = '0; in_pc = '0; in_rob_tag = '0;
        in_alu_tag = '0; in_alu_value = '0; in_lsb_tag = '0; in_lsb_value = '0;
    endtask

    task automatic disp(input logic [5:0] op, input logic [31:0] v1, input logic [3:0] t1,
                        input logic [31:0] v2, input logic [3:0] t2, input logic [3:0] rob);
        in_enable = 1'b1; in_op = op;
        in_value1 = v1; in_tag1 = t1; in_value2 = v2; in_tag2 = t2;
        in_rob_tag = rob; in_imm = imm_of(rob); in_pc = pc_of(rob);
    endtask

    initial begin
        exp_t e;
        int issued, first, last;

        idle();
        rst = 1'b0;
        tick();
        chk("reset_op", 32'(out_op), 0);
        chk("reset_full", 32'(out_full), 0);
        chk("reset_v1", out_value1, 0);
        chk("reset_pc", out_pc, 0);
        chk("reset_rob", 32'(out_rob_tag), 0);
        rst = 1'b1;

        //             en op v1     t1 v2     t2 rob at av     lt lv      e_op e_v1   e_v2   e_rob
        vecs[0]  = '{1, 1, 5,     0, 7,     0, 3,  0, 0,     0, 0,      0, 0,     0,     0};
        vecs[1]  = '{0, 0, 0,     0, 0,     0, 0,  0, 0,     0, 0,      1, 5,     7,     3};
        vecs[2]  = '{0, 0, 0,     0, 0,     0, 0,  0, 0,     0, 0,      0, 0,     0,     0};
        vecs[3]  = '{1, 2, 0,     4, 3,     0, 5,  0, 0,     0, 0,      0, 0,     0,     0};
        vecs[4]  = '{0, 0, 0,     0, 0,     0, 0,  4, 'h10,  0, 0,      0, 0,     0,     0};
        vecs[5]  = '{0, 0, 0,     0, 0,     0, 0,  0, 0,     0, 0,      2, 'h10,  3,     5};
        vecs[6]  = '{1, 3, 1,     0, 0,     6, 7,  0, 0,     6, 'hAB,   0, 0,     0,     0};
        vecs[7]  = '{0, 0, 0,     0, 0,     0, 0,  0, 0,     0, 0,      3, 1,     'hAB,  7};
        vecs[8]  = '{1, 4, 0,     2, 9,     0, 8,  2, 'h55,  2, 'h66,   0, 0,     0,     0};
        vecs[9]  = '{0, 0, 0,     0, 0,     0, 0,  0, 0,     0, 0,      4, 'h55,  9,     8};
        vecs[10] = '{1, 5, 0,     3, 0,     3, 9,  0, 0,     0, 0,      0, 0,     0,     0};
        vecs[11] = '{0, 0, 0,     0, 0,     0, 0,  3, 'h77,  0, 0,      0, 0,     0,     0};
        vecs[12] = '{0, 0, 0,     0, 0,     0, 0,  0, 0,     0, 0,      5, 'h77,  'h77,  9};
        vecs[13] = '{1, 6, 'h11,  0, 'h22,  0, 10, 0, 'h88,  0, 'h99,   0, 0,     0,     0};
        vecs[14] = '{0, 0, 0,     0, 0,     0, 0,  0, 0,     0, 0,      6, 'h11,  'h22,  10};
        vecs[15] = '{0, 0, 0,     0, 0,     0, 0,  0, 0,     0, 0,      0, 0,     0,     0};
        vecs[16] = '{1, 7, 1,     0, 2,     0, 11, 0, 0,     0, 0,      0, 0,     0,     0};
        vecs[17] = '{1, 8, 3,     0, 4,     0, 12, 0, 0,     0, 0,      7, 1,     2,     11};
        vecs[18] = '{0, 0, 0,     0, 0,     0, 0,  0, 0,     0, 0,      8, 3,     4,     12};
        vecs[19] = '{0, 0, 0,     0, 0,     0, 0,  0, 0,     0, 0,      0, 0,     0,     0};

        for (int i = 0; i < 20; i++) begin
            idle();
            if (vecs[i].en) disp(vecs[i].op, vecs[i].v1, vecs[i].t1, vecs[i].v2, vecs[i].t2, vecs[i].rob);
            in_alu_tag = vecs[i].at; in_alu_value = vecs[i].av;
            in_lsb_tag = vecs[i].lt; in_lsb_value = vecs[i].lv;
            chk($sformatf("vec%0d_full", i), 32'(out_full), 0);
            tick();
            idle();
            chk($sformatf("vec%0d_op", i), 32'(out_op), 32'(vecs[i].e_op));
            chk($sformatf("vec%0d_rob", i), 32'(out_rob_tag), 32'(vecs[i].e_rob));
            if (vecs[i].e_op != 0) begin
                chk($sformatf("vec%0d_v1", i), out_value1, vecs[i].e_v1);
                chk($sformatf("vec%0d_v2", i), out_value2, vecs[i].e_v2);
                chk($sformatf("vec%0d_imm", i), out_imm, imm_of(vecs[i].e_rob));
                chk($sformatf("vec%0d_pc", i), out_pc, pc_of(vecs[i].e_rob));
            end
        end

        // Fill every slot with entries waiting on tag 9, then release them together.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] rob;
            rob = 4'(i % 15 + 1);
            chk("fill_full_pre", 32'(out_full), 0);
            disp(7, 0, 9, 32'(i), 0, rob);
            sbq.push_back('{op: 6'd7, v1: 32'h9999, v2: 32'(i), imm: imm_of(rob), pc: pc_of(rob), rob: rob});
            tick();
            idle();
            chk("fill_op", 32'(out_op), 0);
        end
        chk("full_set", 32'(out_full), 1);
        disp(8, 1, 0, 2, 0, 15);
        tick();
        idle();
        chk("overflow_ignored_op", 32'(out_op), 0);
        tick();
        chk("overflow_not_stored", 32'(out_op), 0);
        chk("full_still", 32'(out_full), 1);
        in_alu_tag = 9; in_alu_value = 32'h9999;
        tick();
        idle();
        chk("wake_edge_op", 32'(out_op), 0);
        chk("wake_edge_full", 32'(out_full), 1);
        issued = 0; first = -1; last = -1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (out_op != 0) begin
                if (sbq.size() == 0) begin
                    chk("drain_extra_issue", 32'(out_op), 0);
                end else begin
                    e = sbq.pop_front();
                    chk("drain_op", 32'(out_op), 32'(e.op));
                    chk("drain_v1", out_value1, e.v1);
                    chk("drain_v2", out_value2, e.v2);
                    chk("drain_imm", out_imm, e.imm);
                    chk("drain_pc", out_pc, e.pc);
                    chk("drain_rob", 32'(out_rob_tag), 32'(e.rob));
                end
                if (issued == 0) chk("full_after_first_issue", 32'(out_full), 0);
                if (first < 0) first = c;
                last = c;
                issued++;
            end
        end
        chk("drain_count", 32'(issued), 16);
        chk("drain_first_cycle", 32'(first), 0);
        chk("drain_span", 32'(last - first), 15);

        // Flush with five waiting entries and one ready entry; a dispatch in the flush cycle is dropped.
        for (int i = 0; i < 5; i++) begin
            disp(9, 0, 12, 32'(i), 0, 4'(i + 1));
            tick();
            idle();
        end
        disp(10, 32'hA, 0, 32'hB, 0, 6);
        tick();
        idle();
        disp(11, 1, 0, 1, 0, 7);
        in_flush = 1'b1;
        tick();
        idle();
        chk("flush_op", 32'(out_op), 0);
        chk("flush_rob", 32'(out_rob_tag), 0);
        chk("flush_full", 32'(out_full), 0);
        in_alu_tag = 12; in_alu_value = 32'h1234;
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_flush_quiet", 32'(out_op), 0);
        end

        // Pause: a ready entry must wait, and a broadcast while paused is ignored.
        disp(13, 0, 13, 32'hC, 0, 12);
        tick();
        disp(12, 32'hA, 0, 32'hB, 0, 11);
        tick();
        idle();
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_alu_tag = (k == 1) ? 4'd13 : 4'd0;
            in_alu_value = 32'h5;
            tick();
            chk("pause_op", 32'(out_op), 0);
            chk("pause_rob", 32'(out_rob_tag), 0);
        end
        idle();
        tick();
        chk("resume_op", 32'(out_op), 12);
        chk("resume_v1", out_value1, 32'hA);
        chk("resume_v2", out_value2, 32'hB);
        chk("resume_rob", 32'(out_rob_tag), 11);
        tick();
        chk("paused_bcast_ignored", 32'(out_op), 0);
        in_flush = 1'b1;
        tick();
        idle();

        // Asynchronous reset while one op is on the outputs and another is queued.
        disp(14, 32'h21, 0, 32'h22, 0, 13);
        tick();
        disp(15, 32'h31, 0, 32'h32, 0, 14);
        tick();
        idle();
        chk("pre_reset_op", 32'(out_op), 14);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_op", 32'(out_op), 0);
        chk("async_reset_v1", out_value1, 0);
        chk("async_reset_rob", 32'(out_rob_tag), 0);
        chk("async_reset_full", 32'(out_full), 0);
        #1 rst = 1'b1;
        tick();
        chk("reset_discards_queue", 32'(out_op), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
